// File: rtl/uart_controller.sv
// rtl/uart_controller.sv - bus-mapped 8N1 UART with buffered TX and RX paths
//
// Optional feature macro: UART_LOOPBACK_EN
//   defined   : STATUS write (mask[0]=1) sets loopback = data_wr[0]; while set,
//               the receiver listens to the internal TX line and txd idles high;
//               STATUS bit 5 reads loopback.
//   undefined : STATUS writes are ignored and STATUS bit 5 reads 0.
//
// Ports (uart_controller):
//   clk        in   1   main clock
//   rst_n      in   1   asynchronous active-low reset
//   address    in  32   bus address, only address[2] decoded (0 DATA, 1 STATUS)
//   read       in   1   read strobe, one cycle per access
//   write      in   1   write strobe, held while stall=1
//   data_wr    in  32   write data
//   mask       in   4   byte mask, only mask[0] honoured
//   stall      out  1   hold request while the TX queue is full
//   data_rd    out 32   combinational read data
//   data_rd_2  out 32   constant 0
//   interrupt  out  6   bit 0 = receive data pending, bits 5:1 = 0
//   txd        out  1   serial out, idle high
//   rxd        in   1   serial in, asynchronous to clk
//
// STATUS layout: {26'h0, loopback, frame_err, overrun, tx_idle, rx_nonempty, tx_not_full}
//
// Ports (uart_fifo): clk, rst_n, push/wdata, pop, head, full, empty.
// Pointers carry an extra wrap bit so full and empty need no separate counter.

`timescale 1ns/1ps

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

module uart_controller #(
  parameter int CLK_FREQ   = 60_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] data_wr,
  input  logic [3:0]  mask,
  output logic        stall,
  output logic [31:0] data_rd,
  output logic [31:0] data_rd_2,
  output logic [5:0]  interrupt,
  output logic        txd,
  input  logic        rxd
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // Bus decode
  logic sel_status;
  logic data_rd_en;
  logic stat_rd_en;
  logic data_wr_req;

  // TX queue and FSM
  logic        tx_push;
  logic        tx_pop;
  logic [7:0]  tx_head;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_idle;
  uart_state_t tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]  tx_idx, tx_idx_nx;
  logic [7:0]  tx_shift, tx_shift_nx;
  logic        tx_line, tx_line_nx;

  // RX synchroniser, FSM and queue
  logic        rx_src;
  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  uart_state_t rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]  rx_idx, rx_idx_nx;
  logic [7:0]  rx_shift, rx_shift_nx;
  logic        rx_push;
  logic        rx_pop;
  logic [7:0]  rx_head;
  logic        rx_full;
  logic        rx_empty;

  // Sticky flags
  logic        frame_err;
  logic        overrun;
  logic        frame_set;
  logic        overrun_set;
  logic        loop_bit;

  logic        unused_bits;

  assign sel_status  = address[2];
  assign data_rd_en  = read && !sel_status;
  assign stat_rd_en  = read && sel_status;
  assign data_wr_req = write && !sel_status && mask[0];

  // Stall only when the write really cannot land this cycle; a TX pop on the
  // same edge makes room.
  assign stall   = data_wr_req && tx_full && !tx_pop;
  assign tx_push = data_wr_req && !stall;
  assign rx_pop  = data_rd_en;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .wdata (data_wr[7:0]),
    .pop   (tx_pop),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .wdata (rx_shift),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // ---------------------------------------------------------------- TX FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_idx   <= tx_idx_nx;
      tx_shift <= tx_shift_nx;
      tx_line  <= tx_line_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_idx_nx   = tx_idx;
    tx_shift_nx = tx_shift;
    tx_pop      = 1'b0;
    tx_line_nx  = 1'b1;
    unique case (tx_state)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_state_nx = S_START;
          tx_cnt_nx   = '0;
          tx_shift_nx = tx_head;
          tx_pop      = 1'b1;
        end
      end
      S_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_nx = S_DATA;
          tx_cnt_nx   = '0;
          tx_idx_nx   = '0;
        end else begin
          tx_cnt_nx = tx_cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx = '0;
          tx_idx_nx = tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_state_nx = S_STOP;
        end else begin
          tx_cnt_nx = tx_cnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx = '0;
          // Chain straight into the next start bit so queued bytes leave gap-free.
          if (!tx_empty) begin
            tx_state_nx = S_START;
            tx_shift_nx = tx_head;
            tx_pop      = 1'b1;
          end else begin
            tx_state_nx = S_IDLE;
          end
        end else begin
          tx_cnt_nx = tx_cnt + CNT_ONE;
        end
      end
      default: tx_state_nx = S_IDLE;
    endcase
    // The line is registered from the next state so txd changes exactly on
    // the bit boundary and never glitches.
    case (tx_state_nx)
      S_START: tx_line_nx = 1'b0;
      S_DATA:  tx_line_nx = tx_shift_nx[tx_idx_nx];
      default: tx_line_nx = 1'b1;
    endcase
  end

  assign tx_idle = (tx_state == S_IDLE) && tx_empty;

  // ---------------------------------------------------------------- RX path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_idx   <= rx_idx_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_idx_nx   = rx_idx;
    rx_shift_nx = rx_shift;
    rx_push     = 1'b0;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
    unique case (rx_state)
      S_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_nx = S_START;
          rx_cnt_nx   = '0;
        end
      end
      S_START: begin
        // Half a bit in: a high line means the falling edge was a glitch.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx = '0;
          rx_idx_nx = '0;
          rx_state_nx = rx_sync ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_nx = rx_cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_sync, rx_shift[7:1]};
          rx_idx_nx   = rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_state_nx = S_STOP;
        end else begin
          rx_cnt_nx = rx_cnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx   = '0;
          rx_state_nx = S_IDLE;
          if (!rx_sync) begin
            frame_set = 1'b1;
          end else if (rx_full && !(rx_pop && !rx_empty)) begin
            overrun_set = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
        end else begin
          rx_cnt_nx = rx_cnt + CNT_ONE;
        end
      end
      default: rx_state_nx = S_IDLE;
    endcase
  end

  // A STATUS read clears the flags, but a new event on the same edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set   | (frame_err & ~stat_rd_en);
      overrun   <= overrun_set | (overrun   & ~stat_rd_en);
    end
  end

  // ---------------------------------------------------------------- loopback
`ifdef UART_LOOPBACK_EN
  logic loopback;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loopback <= 1'b0;
    end else if (write && sel_status && mask[0]) begin
      loopback <= data_wr[0];
    end
  end

  assign rx_src   = loopback ? tx_line : rxd;
  assign txd      = loopback ? 1'b1 : tx_line;
  assign loop_bit = loopback;
`else
  assign rx_src   = rxd;
  assign txd      = tx_line;
  assign loop_bit = 1'b0;
`endif

  // ---------------------------------------------------------------- bus read
  always_comb begin
    data_rd = '0;
    if (data_rd_en) begin
      data_rd = {24'h0, (rx_empty ? 8'h00 : rx_head)};
    end else if (stat_rd_en) begin
      data_rd = {26'h0, loop_bit, frame_err, overrun, tx_idle, !rx_empty, !tx_full};
    end
  end

  assign data_rd_2 = '0;
  assign interrupt = {5'b0, !rx_empty};

  assign unused_bits = ^{address[31:3], address[1:0], data_wr[31:8], mask[3:1]};

endmodule

// File: doc/uart_controller.md
Name: uart_controller

Overview:
- Bus slave that sits directly downstream of the system bus at address prefix 0x03.
- Turns bus reads and writes into 8N1 serial traffic on the UART pins.
- Buffers both directions in small FIFOs.
- Raises the UART interrupt line (IRQ_UART, bit 0) while receive data is pending.

Parameters:
- CLK_FREQ, 60_000_000: main clock frequency in Hz.
- BAUD, 115200: line rate. DIV = CLK_FREQ/BAUD, rounded to nearest. Default DIV = 521.
- FIFO_DEPTH, 8: entries per FIFO. Must be a power of 2, at least 2.

Ports:
- clk  in  1  main clock (base clock domain)
- rst_n  in  1  asynchronous active-low reset
- address  in  32  bus address; only address[2] is decoded (0 = DATA, 1 = STATUS)
- read  in  1  bus read strobe, one cycle per access
- write  in  1  bus write strobe, one cycle per access unless stalled
- data_wr  in  32  write data
- mask  in  4  byte mask; only mask[0] is honoured
- stall  out  1  hold request
- data_rd  out  32  read data
- data_rd_2  out  32  tied to 0
- interrupt  out  6  bit 0 = rx_nonempty; bits 5:1 tied to 0
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, asynchronous

Behaviour:
- Reset values: txd=1, stall=0, data_rd=0, interrupt=0. Both FIFOs empty; sticky flags cleared; TX and RX FSMs in IDLE.
- Reset asserted mid-frame aborts the frame immediately. txd returns to 1 asynchronously.
- Read data is combinational (0-cycle latency). Side effects take place at the clock edge ending the access.
- DATA read:
  - data_rd = {24'h0, rx_head}.
  - Pops RX FIFO if it is non-empty.
  - If RX FIFO is empty, returns 0 and pops nothing.
- DATA write with mask[0]=1:
  - Pushes data_wr[7:0] into TX FIFO.
  - If TX FIFO is full, stall=1 combinationally for as long as it stays full. The push happens on the first cycle with space.
- DATA write with mask[0]=0: ignored.
- STATUS read, data_rd = {27'h0, frame_err, overrun, tx_idle, rx_nonempty, tx_not_full}.
  - The read clears frame_err and overrun at the end of the access.
  - A flag set in the same cycle as the clear wins (stays 1).
- STATUS write: ignored (see Optional Feature).
- Simultaneous cases:
  - A pop of a full RX FIFO and a new RX byte in the same cycle: both occur, no overrun.
  - TX FSM pop and bus push on a full TX FIFO in the same cycle: the push is accepted.
- TX FSM, states IDLE -> START -> DATA -> STOP:
  - Leaves IDLE when the TX FIFO is non-empty; pops the FIFO on that transition.
  - Each bit lasts exactly DIV clocks.
  - Data is sent LSB first: 8 bits, using a 3-bit index that wraps.
  - The STOP bit is high for DIV clocks. Then the FSM goes back to IDLE, or straight to START if the FIFO is non-empty (back-to-back frames, no gap).
  - tx_idle = (state==IDLE) && FIFO empty.
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - RX FSM, states IDLE -> START -> DATA -> STOP.
  - IDLE waits for a 1->0 edge.
  - START samples at DIV/2. If the line is high there, the start is a false start and the FSM returns to IDLE.
  - DATA samples every DIV clocks, shifting LSB first.
  - STOP samples at the middle of the stop bit:
    - stop bit = 1: push the byte.
    - stop bit = 0: drop the byte and set frame_err.
  - On a push with RX FIFO full: drop the byte and set overrun.
  - Returns to IDLE right after the stop sample.
- FIFOs use circular pointers with an extra wrap bit. Full when the indices are equal and the wrap bits differ.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Enabled:
  - STATUS write with mask[0]=1 sets loopback = data_wr[0]. Reset value is 0.
  - While loopback=1, the RX synchroniser input is driven by the internal TX line and the txd pin is held at 1.
  - STATUS bit 5 reads loopback.
- Disabled: STATUS writes are ignored and bit 5 reads 0.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000, so DIV=10):
- Write DATA 0x000000A5, mask=4'b0001 -> txd shows start bit, then 1,0,1,0,0,1,0,1, then stop; each bit exactly 10 clocks; tx_idle=1 after 100 clocks.
- Drive rxd serial byte 0x3C -> interrupt[0]=1; DATA read returns 0x0000003C; interrupt[0]=0 on the next cycle; STATUS reads 0x00000005.
- Write 9 bytes back-to-back with FIFO_DEPTH=8 while TX is busy -> stall=1 on the 9th write only; stall drops once the TX FSM pops a byte; all 9 bytes transmitted in order with no gaps.
- Receive 9 bytes without reading -> STATUS bit 3 (overrun)=1; 8 DATA reads return bytes 1..8; STATUS read clears bit 3, and a second read shows 0.
- rxd stop bit forced to 0 on byte 0x55 -> byte not queued; STATUS bit 4=1. Separately, a 3-clock low glitch on rxd -> no byte received, no flags set.
- rst_n pulsed low at the 5th bit of a TX frame -> txd=1 immediately; FIFOs empty; STATUS reads 0x00000005 with loopback off.
